// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing constants (pixel clock 25 MHz).
//   - Derived line/frame totals for the default timing.
//   - FSM state encoding used by vga_timing_gen.
package vga_timing_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int LOCK_WAIT_DEF = 1024;
  localparam int IRQ_LEN_DEF   = 64;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/vga_timing_sync2.sv
// vga_timing_sync2: two-flop synchroniser bringing the PLL lock flag into
// the pixel clock domain. Both stages clear to 0 on reset so the raster
// never starts before the lock has been re-observed.
// Ports:
//   clk   - pixel clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output (two clocks of latency)
module vga_timing_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (640x480@60 by default).
// Waits for the PLL lock flag, requires it to stay high for LOCK_WAIT
// clocks, then free-runs the horizontal/vertical counters until the lock
// drops. All outputs are registered and reflect the counters of the
// previous cycle.
// Optional feature macro: VGA_TIMING_IRQ_EN adds irq_n, an active-low
// frame interrupt pulse of IRQ_LEN clocks at the start of vertical blank.
// Ports:
//   clk     - 25 MHz pixel clock
//   rst_n   - synchronous active-low reset
//   locked  - PLL lock flag (asynchronous, synchronised internally)
//   hs, vs  - horizontal / vertical sync, active low
//   de      - visible-area data enable
//   x, y    - current column / line
//   frame   - one-clock pulse at pixel (0,0) of every frame
//   running - high while the raster is running
//   irq_n   - (VGA_TIMING_IRQ_EN only) active-low frame interrupt
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS     = H_VIS_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VIS     = V_VIS_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int LOCK_WAIT = LOCK_WAIT_DEF
`ifdef VGA_TIMING_IRQ_EN
  , parameter int IRQ_LEN = IRQ_LEN_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame,
  output logic       running
`ifdef VGA_TIMING_IRQ_EN
  , output logic     irq_n
`endif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

  logic          locks_s;
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] settle_cnt;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          live;

  vga_timing_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locks_s)
  );

  // A RUN cycle that also sees lock loss is treated as already stopped:
  // its outputs and counters go straight back to the idle values.
  assign live = (state == RUN) && locks_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nxt;
  end

  // Lock loss wins over settle completion.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (locks_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!locks_s)                       state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN:       if (!locks_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  // ---- counter stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      if (live) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end else begin
        hcnt <= '0;
        vcnt <= '0;
      end
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n || !live) begin
      hs      <= 1'b1;
      vs      <= 1'b1;
      de      <= 1'b0;
      x       <= '0;
      y       <= '0;
      frame   <= 1'b0;
      running <= 1'b0;
    end else begin
      hs      <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
      vs      <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
      de      <= (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
      x       <= hcnt;
      y       <= vcnt;
      frame   <= (hcnt == 10'd0) && (vcnt == 10'd0);
      running <= 1'b1;
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  localparam int IW = (IRQ_LEN > 1) ? $clog2(IRQ_LEN) : 1;
  localparam logic [IW-1:0] IRQ_RELOAD = IW'(IRQ_LEN - 1);

  logic [IW-1:0] irq_cnt;

  // irq_cnt holds the remaining low clocks after the current one; irq_n
  // returns high on the edge that finds it exhausted.
  always_ff @(posedge clk) begin
    if (!rst_n || !live) begin
      irq_cnt <= '0;
      irq_n   <= 1'b1;
    end else if ((hcnt == 10'd0) && (vcnt == V_VIS_C)) begin
      irq_cnt <= IRQ_RELOAD;
      irq_n   <= 1'b0;
    end else if (irq_cnt != '0) begin
      irq_cnt <= irq_cnt - 1'b1;
    end else begin
      irq_n   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so several whole frames
// fit in a short run. A reference model tracks the raster as a linear
// pixel index within the frame and is compared against the DUT every cycle.
module tb_vga_timing_gen;

  localparam int HV = 64, HF = 4, HS = 12, HB = 8;
  localparam int VV = 48, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LW = 4;
  localparam int IL = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       hs, vs, de, frame, running;
  logic [9:0] x, y;
`ifdef VGA_TIMING_IRQ_EN
  logic       irq_n;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_WAIT(LW)
`ifdef VGA_TIMING_IRQ_EN
    , .IRQ_LEN(IL)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .frame(frame), .running(running)
`ifdef VGA_TIMING_IRQ_EN
    , .irq_n(irq_n)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 settling, 2 raster; pos is the pixel index in the frame.
  int   m_mode = 0, m_settle = 0, m_pos = 0, m_irq_left = 0;
  logic m_ls1 = 1'b0, m_ls2 = 1'b0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_frame = 1'b0, e_run = 1'b0, e_irq_n = 1'b1;
  int   e_x = 0, e_y = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_settle = 0; m_pos = 0; m_irq_left = 0;
      m_ls1 = 1'b0; m_ls2 = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_frame = 1'b0; e_run = 1'b0;
      e_x = 0; e_y = 0; e_irq_n = 1'b1;
    end else begin
      if (m_mode == 2 && m_ls2) begin
        e_x = m_pos % HT;
        e_y = m_pos / HT;
        e_de = (e_x < HV) && (e_y < VV);
        e_hs = !((e_x >= HV + HF) && (e_x < HV + HF + HS));
        e_vs = !((e_y >= VV + VF) && (e_y < VV + VF + VS));
        e_frame = (m_pos == 0);
        e_run = 1'b1;
        if (m_pos == VV * HT) m_irq_left = IL;
        else if (m_irq_left > 0) m_irq_left--;
        m_pos = (m_pos + 1) % FT;
      end else begin
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_frame = 1'b0; e_run = 1'b0;
        e_x = 0; e_y = 0; m_irq_left = 0;
      end
      e_irq_n = (m_irq_left == 0);
      case (m_mode)
        0: if (m_ls2) begin m_mode = 1; m_settle = 0; end
        1: begin
          if (!m_ls2) m_mode = 0;
          else if (m_settle == LW - 1) begin m_mode = 2; m_pos = 0; end
          else m_settle++;
        end
        default: if (!m_ls2) m_mode = 0;
      endcase
      m_ls2 = m_ls1;
      m_ls1 = locked;
    end
  end

  always @(negedge clk) begin
    check("model", {hs, vs, de, frame, running,
`ifdef VGA_TIMING_IRQ_EN
                    irq_n,
`endif
                    x, y},
                   {e_hs, e_vs, e_de, e_frame, e_run,
`ifdef VGA_TIMING_IRQ_EN
                    e_irq_n,
`endif
                    10'(e_x), 10'(e_y)});
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       run;
    logic       frame;
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit ok;
    int cnt, first, n, ly;

    // Three reset clocks with lock present, then lock held: frame after
    // 2 sync edges + 1 sampling edge + LW settle edges + 1 output edge.
    for (int i = 0; i < 13; i++)
      tbl[i] = '{rst_n: (i >= 3), locked: 1'b1, run: 1'b0, frame: 1'b0,
                 de: 1'b0, hs: 1'b1, vs: 1'b1, x: 10'd0, y: 10'd0};
    tbl[10].run = 1'b1; tbl[10].frame = 1'b1; tbl[10].de = 1'b1;
    tbl[11].run = 1'b1; tbl[11].de = 1'b1; tbl[11].x = 10'd1;
    tbl[12].run = 1'b1; tbl[12].de = 1'b1; tbl[12].x = 10'd2;

    for (int i = 0; i < 13; i++) begin
      rst_n  = tbl[i].rst_n;
      locked = tbl[i].locked;
      tick();
      check($sformatf("vec%0d", i), {running, frame, de, hs, vs, x, y},
            {tbl[i].run, tbl[i].frame, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].x, tbl[i].y});
`ifdef VGA_TIMING_IRQ_EN
      check($sformatf("vec%0d_irq", i), irq_n, 1'b1);
`endif
    end

    // ---- one full line ----
    ok = 0;
    for (int i = 0; i < 2 * HT; i++) begin tick(); if (x == 10'd0) begin ok = 1; break; end end
    check("line_start_found", ok, 1'b1);
    ly = y; cnt = 0; first = -1; n = 0;
    for (int i = 0; i < HT; i++) begin
      if (de) cnt++;
      if (!hs) begin if (first < 0) first = x; n++; end
      if (i == HT - 1) check("line_last_x", x, HT - 1);
      tick();
    end
    check("de_width", cnt, HV);
    check("hs_start", first, HV + HF);
    check("hs_width", n, HS);
    check("wrap_x", x, 0);
    check("wrap_y", y, ly + 1);

    // ---- frame period and vsync lines ----
    ok = 0;
    for (int i = 0; i < FT + 2 * HT; i++) begin tick(); if (frame) begin ok = 1; break; end end
    check("frame_found", ok, 1'b1);
    n = 0; first = -1; cnt = 0;
    for (int i = 0; i < FT + 10; i++) begin
      tick(); n++;
      if (x == 10'd0 && !vs) begin if (first < 0) first = y; cnt++; end
      if (frame) break;
    end
    check("frame_period", n, FT);
    check("vs_start", first, VV + VF);
    check("vs_lines", cnt, VS);

`ifdef VGA_TIMING_IRQ_EN
    // ---- interrupt pulse ----
    ok = 0;
    for (int i = 0; i < FT + 10; i++) begin tick(); if (!irq_n) begin ok = 1; break; end end
    check("irq_found", ok, 1'b1);
    check("irq_at_x", x, 0);
    check("irq_at_y", y, VV);
    n = 0;
    for (int i = 0; i < IL + 10 && !irq_n; i++) begin tick(); n++; end
    check("irq_width", n, IL);
`endif

    // ---- lock loss mid-line and relock ----
    ok = 0;
    for (int i = 0; i < FT + 10; i++) begin tick(); if (x == 10'd30 && y == 10'd10) begin ok = 1; break; end end
    check("loss_point_found", ok, 1'b1);
    locked = 1'b0;
    tick(); tick();
    check("loss_still_running", running, 1'b1);
    tick();
    check("loss_idle", {running, frame, de, hs, vs, x, y}, {5'b00011, 20'd0});
    locked = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && !frame; i++) begin tick(); n++; end
    check("relock_latency", n, 3 + LW + 1);

`ifdef VGA_TIMING_IRQ_EN
    // ---- lock loss while irq_n low ----
    ok = 0;
    for (int i = 0; i < FT + 10; i++) begin tick(); if (!irq_n) begin ok = 1; break; end end
    check("irq2_found", ok, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    locked = 1'b0;
    tick(); tick();
    check("irq_loss_low", irq_n, 1'b0);
    tick();
    check("irq_loss_high", irq_n, 1'b1);
    locked = 1'b1;
`endif

    // ---- reset while running ----
    for (int i = 0; i < 200; i++) tick();
    check("pre_reset_running", running, 1'b1);
    rst_n = 1'b0;
    tick();
    check("reset_idle", {running, de, hs, vs, x, y}, {4'b0011, 20'd0});
    rst_n = 1'b1;

    // ---- randomized lock / reset activity against the model ----
    for (int i = 0; i < 12000; i++) begin
      tick();
      if (rst_n == 1'b0) begin
        if ($urandom_range(2, 0) == 0) rst_n = 1'b1;
      end else if ($urandom_range(4999, 0) == 0) begin
        rst_n = 1'b0;
      end
      if (locked) begin
        if ($urandom_range(3999, 0) == 0) locked = 1'b0;
      end else if ($urandom_range(7, 0) == 0) begin
        locked = 1'b1;
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
